mem_port_arbiter: RTL and testbench

// Shares one single-port synchronous RAM between instruction fetch (IF, read-only) and the MEM stage (load/store).

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between instruction
// fetch (read-only) and the MEM stage (load/store). MEM has priority, and an
// aging counter makes sure a starved fetch eventually wins.
//
// Handshake: a requester raises req with its operands and holds them until its
// valid pulse. gnt is a combinational, single-cycle acknowledgement that is only
// ever issued in IDLE. The operands are latched on the clock edge that ends the
// grant cycle. valid is a one-cycle pulse in RESP. req is ignored outside IDLE,
// so a requester may drop or renew req on the edge that ends its valid cycle.
module mem_port_arbiter #(
  parameter int size         = 32,
  parameter int WAIT_STATES  = 0,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req_i,
  input  logic [size-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_valid_o,
  output logic [size-1:0] if_rdata_o,
  input  logic            mem_req_i,
  input  logic            mem_we_i,
  input  logic [size-1:0] mem_addr_i,
  input  logic [size-1:0] mem_wdata_i,
  input  logic [2:0]      mem_ctrl_i,
  output logic            mem_gnt_o,
  output logic            mem_valid_o,
  output logic [size-1:0] mem_rdata_o,
  output logic            ram_en_o,
  output logic            ram_rw_o,
  output logic [size-1:0] ram_addr_o,
  output logic [size-1:0] ram_wdata_o,
  output logic [2:0]      ram_ctrl_o,
  input  logic [size-1:0] ram_rdata_i,
  output logic [1:0]      dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // A zero limit or zero wait states still needs a one-bit counter.
  localparam int CNT_W  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int WCNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0]  AGE_MAX   = CNT_W'(STARVE_LIMIT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_STATES);
  localparam logic [2:0]        CTRL_WORD = 3'b010;

  state_t            state_q, state_d;
  logic              owner_if_q;
  logic              we_q;
  logic [CNT_W-1:0]  age_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic [size-1:0]   addr_q, wdata_q;
  logic [2:0]        ctrl_q;
  logic [size-1:0]   if_rdata_q, mem_rdata_q;
  logic              grant_if, grant_mem, busy_last;

  // Arbitration in IDLE and next-state selection.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    state_d   = state_q;
    busy_last = (wcnt_q == WCNT_LAST);
    case (state_q)
      IDLE: begin
        if (if_req_i && mem_req_i) begin
          if ((STARVE_LIMIT != 0) && (age_q == AGE_MAX)) grant_if = 1'b1;
          else                                           grant_mem = 1'b1;
        end else if (if_req_i) begin
          grant_if = 1'b1;
        end else if (mem_req_i) begin
          grant_mem = 1'b1;
        end
        if (grant_if || grant_mem) state_d = BUSY;
      end
      BUSY:    if (busy_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Latch the winner's operands on the grant edge; they stay put until the next grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_if_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ctrl_q     <= '0;
    end else if (grant_if) begin
      owner_if_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= if_addr_i;
      ctrl_q     <= CTRL_WORD;
    end else if (grant_mem) begin
      owner_if_q <= 1'b0;
      we_q       <= mem_we_i;
      addr_q     <= mem_addr_i;
      wdata_q    <= mem_wdata_i;
      ctrl_q     <= mem_ctrl_i;
    end
  end

  // Wait-state counter: counts 0..WAIT_STATES while BUSY, idles at zero otherwise.
  always_ff @(posedge clk) begin
    if (reset)                 wcnt_q <= '0;
    else if (state_q == BUSY)  wcnt_q <= busy_last ? '0 : wcnt_q + WCNT_W'(1);
    else                       wcnt_q <= '0;
  end

  // Aging: count fetch losses to MEM, saturating; any fetch grant clears it.
  always_ff @(posedge clk) begin
    if (reset)                                              age_q <= '0;
    else if (grant_if)                                      age_q <= '0;
    else if (grant_mem && if_req_i && (age_q != AGE_MAX))   age_q <= age_q + CNT_W'(1);
  end

  // Capture read data in the last BUSY cycle into the owner's register; stores leave it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else if ((state_q == BUSY) && busy_last && !we_q) begin
      if (owner_if_q) if_rdata_q  <= ram_rdata_i;
      else            mem_rdata_q <= ram_rdata_i;
    end
  end

  assign if_gnt_o    = grant_if;
  assign mem_gnt_o   = grant_mem;
  assign ram_en_o    = (state_q == BUSY);
  assign ram_rw_o    = (state_q == BUSY) && we_q;
  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign ram_ctrl_o  = ctrl_q;
  assign if_valid_o  = (state_q == RESP) && owner_if_q;
  assign mem_valid_o = (state_q == RESP) && !owner_if_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiter instances (index 0: no wait states,
// starvation limit 2; index 1: two wait states, strict MEM priority), each in
// front of a RAM model that only returns good data in the last busy cycle.
module tb_mem_port_arbiter;

  localparam int WS0 = 0;
  localparam int WS1 = 2;

  // Clock and reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        if_req[2];
  logic [31:0] if_addr[2];
  logic        if_gnt[2];
  logic        if_valid[2];
  logic [31:0] if_rdata[2];
  logic        mem_req[2];
  logic        mem_we[2];
  logic [31:0] mem_addr[2];
  logic [31:0] mem_wdata[2];
  logic [2:0]  mem_ctrl[2];
  logic        mem_gnt[2];
  logic        mem_valid[2];
  logic [31:0] mem_rdata[2];
  logic        ram_en[2];
  logic        ram_rw[2];
  logic [31:0] ram_addr[2];
  logic [31:0] ram_wdata[2];
  logic [2:0]  ram_ctrl[2];
  logic [31:0] ram_rdata[2];
  logic [1:0]  dbg_state[2];

  mem_port_arbiter #(.size(32), .WAIT_STATES(WS0), .STARVE_LIMIT(2)) dut0 (
    .clk(clk), .reset(reset),
    .if_req_i(if_req[0]), .if_addr_i(if_addr[0]), .if_gnt_o(if_gnt[0]),
    .if_valid_o(if_valid[0]), .if_rdata_o(if_rdata[0]),
    .mem_req_i(mem_req[0]), .mem_we_i(mem_we[0]), .mem_addr_i(mem_addr[0]),
    .mem_wdata_i(mem_wdata[0]), .mem_ctrl_i(mem_ctrl[0]), .mem_gnt_o(mem_gnt[0]),
    .mem_valid_o(mem_valid[0]), .mem_rdata_o(mem_rdata[0]),
    .ram_en_o(ram_en[0]), .ram_rw_o(ram_rw[0]), .ram_addr_o(ram_addr[0]),
    .ram_wdata_o(ram_wdata[0]), .ram_ctrl_o(ram_ctrl[0]), .ram_rdata_i(ram_rdata[0]),
    .dbg_state_o(dbg_state[0])
  );

  mem_port_arbiter #(.size(32), .WAIT_STATES(WS1), .STARVE_LIMIT(0)) dut1 (
    .clk(clk), .reset(reset),
    .if_req_i(if_req[1]), .if_addr_i(if_addr[1]), .if_gnt_o(if_gnt[1]),
    .if_valid_o(if_valid[1]), .if_rdata_o(if_rdata[1]),
    .mem_req_i(mem_req[1]), .mem_we_i(mem_we[1]), .mem_addr_i(mem_addr[1]),
    .mem_wdata_i(mem_wdata[1]), .mem_ctrl_i(mem_ctrl[1]), .mem_gnt_o(mem_gnt[1]),
    .mem_valid_o(mem_valid[1]), .mem_rdata_o(mem_rdata[1]),
    .ram_en_o(ram_en[1]), .ram_rw_o(ram_rw[1]), .ram_addr_o(ram_addr[1]),
    .ram_wdata_o(ram_wdata[1]), .ram_ctrl_o(ram_ctrl[1]), .ram_rdata_i(ram_rdata[1]),
    .dbg_state_o(dbg_state[1])
  );

  // RAM content model
  function automatic logic [31:0] ram_fn(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], 16'h0} ^ 32'h1357_9BDF ^ a;
  endfunction

  // RAM model: good data only in the last busy cycle, garbage otherwise
  int rcnt0, rcnt1;
  always @(posedge clk) begin
    rcnt0 <= ram_en[0] ? rcnt0 + 1 : 0;
    rcnt1 <= ram_en[1] ? rcnt1 + 1 : 0;
  end
  assign ram_rdata[0] = (ram_en[0] && rcnt0 == WS0) ? ram_fn(ram_addr[0]) : 32'hBAD0_BAD0;
  assign ram_rdata[1] = (ram_en[1] && rcnt1 == WS1) ? ram_fn(ram_addr[1]) : 32'hBAD0_BAD0;

  // Scoreboard: {instance, is_if, data}
  int n_checks = 0;
  int n_errors = 0;
  logic [33:0] exp_q[$];
  logic [31:0] last_mem[2];

  function automatic void check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void sb_push(input int d, input bit is_if, input logic [31:0] data);
    exp_q.push_back({d[0], is_if, data});
  endfunction

  function automatic void sb_pop(input int d, input bit is_if, input logic [31:0] data);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      check_eq("unexpected_valid", {30'b0, d[0], is_if}, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check_eq("sb_tag", {30'b0, d[0], is_if}, {30'b0, e[33:32]});
      check_eq("sb_data", data, e[31:0]);
    end
  endfunction

  // Monitor: every valid pulse must match the head of the expected queue
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (if_valid[d])  sb_pop(d, 1'b1, if_rdata[d]);
      if (mem_valid[d]) sb_pop(d, 1'b0, mem_rdata[d]);
    end
  end

  function automatic int ws(input int d);
    return (d == 0) ? WS0 : WS1;
  endfunction

  // Driver: one access, called at a negedge; checks grant, RAM side and valid timing
  task automatic access(input int d, input bit is_if, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] ctrl, input logic [31:0] exp_data);
    bit got;
    if (is_if) begin
      if_req[d] = 1'b1; if_addr[d] = addr;
    end else begin
      mem_req[d] = 1'b1; mem_we[d] = we; mem_addr[d] = addr;
      mem_wdata[d] = wdata; mem_ctrl[d] = ctrl;
    end
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      #1;
      if (is_if ? if_gnt[d] : mem_gnt[d]) got = 1'b1;
      else @(negedge clk);
    end
    check_eq("grant_seen", {31'b0, got}, 32'd1);
    if (got) begin
      sb_push(d, is_if, exp_data);
      for (int k = 0; k <= ws(d); k++) begin
        @(negedge clk);
        check_eq("busy_en", {31'b0, ram_en[d]}, 32'd1);
        check_eq("busy_rw", {31'b0, ram_rw[d]}, {31'b0, is_if ? 1'b0 : we});
        check_eq("busy_addr", ram_addr[d], addr);
        check_eq("busy_ctrl", {29'b0, ram_ctrl[d]}, {29'b0, is_if ? 3'b010 : ctrl});
        if (!is_if && we) check_eq("busy_wdata", ram_wdata[d], wdata);
      end
      @(negedge clk);
      check_eq("resp_en", {31'b0, ram_en[d]}, 32'd0);
      check_eq("resp_rw", {31'b0, ram_rw[d]}, 32'd0);
      check_eq("resp_valid", {31'b0, is_if ? if_valid[d] : mem_valid[d]}, 32'd1);
    end
    if (is_if) if_req[d] = 1'b0;
    else       mem_req[d] = 1'b0;
  endtask

  typedef struct {
    int          d;
    bit          is_if;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctrl;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    string order;
    int n, mem_n, ifg;
    logic [31:0] model_mem[2];

    for (int d = 0; d < 2; d++) begin
      if_req[d] = 0; if_addr[d] = 0; mem_req[d] = 0; mem_we[d] = 0;
      mem_addr[d] = 0; mem_wdata[d] = 0; mem_ctrl[d] = 0; last_mem[d] = 0;
    end

    // Vector table: {instance, is_if, we, addr, wdata, ctrl, expected rdata}
    vecs[0]  = '{0, 1'b1, 1'b0, 32'h100, 32'h0,    3'b000, 32'h0};
    vecs[1]  = '{0, 1'b0, 1'b0, 32'h24,  32'h0,    3'b100, 32'h0};
    vecs[2]  = '{0, 1'b0, 1'b1, 32'h20,  32'h55,   3'b000, 32'h0};
    vecs[3]  = '{0, 1'b1, 1'b0, 32'h104, 32'h0,    3'b000, 32'h0};
    vecs[4]  = '{1, 1'b0, 1'b0, 32'h200, 32'h0,    3'b010, 32'h0};
    vecs[5]  = '{1, 1'b0, 1'b1, 32'h204, 32'hCAFE, 3'b001, 32'h0};
    vecs[6]  = '{1, 1'b1, 1'b0, 32'h208, 32'h0,    3'b000, 32'h0};
    for (int i = 7; i < NV; i++) begin
      vecs[i].d     = $urandom_range(0, 1);
      vecs[i].is_if = 1'($urandom_range(0, 1));
      vecs[i].we    = vecs[i].is_if ? 1'b0 : 1'($urandom_range(0, 1));
      vecs[i].addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      vecs[i].wdata = $urandom;
      vecs[i].ctrl  = 3'($urandom_range(0, 7));
    end
    // Expected data: loads return RAM content, stores leave mem_rdata as it was
    model_mem[0] = 32'h0; model_mem[1] = 32'h0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].is_if) begin
        vecs[i].exp_data = ram_fn(vecs[i].addr);
      end else if (vecs[i].we) begin
        vecs[i].exp_data = model_mem[vecs[i].d];
      end else begin
        vecs[i].exp_data = ram_fn(vecs[i].addr);
        model_mem[vecs[i].d] = vecs[i].exp_data;
      end
    end

    // Reset and reset-state checks
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_state", {30'b0, dbg_state[d]}, 32'd0);
      check_eq("rst_gnt", {30'b0, if_gnt[d], mem_gnt[d]}, 32'd0);
      check_eq("rst_valid", {30'b0, if_valid[d], mem_valid[d]}, 32'd0);
      check_eq("rst_en_rw", {30'b0, ram_en[d], ram_rw[d]}, 32'd0);
      check_eq("rst_addr", ram_addr[d], 32'd0);
      check_eq("rst_wdata", ram_wdata[d], 32'd0);
      check_eq("rst_ctrl", {29'b0, ram_ctrl[d]}, 32'd0);
      check_eq("rst_if_rdata", if_rdata[d], 32'd0);
      check_eq("rst_mem_rdata", mem_rdata[d], 32'd0);
    end

    // Table-driven single accesses
    for (int i = 0; i < NV; i++) begin
      access(vecs[i].d, vecs[i].is_if, vecs[i].we, vecs[i].addr,
             vecs[i].wdata, vecs[i].ctrl, vecs[i].exp_data);
    end
    @(negedge clk);

    // Reset in the first BUSY cycle drops the access
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_addr[0] = 32'h90; mem_ctrl[0] = 3'b010;
    #1;
    check_eq("rstbusy_mem_wins", {30'b0, mem_gnt[0], if_gnt[0]}, 32'd2);
    @(negedge clk);
    check_eq("rstbusy_en_before", {31'b0, ram_en[0]}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rstbusy_en_after", {31'b0, ram_en[0]}, 32'd0);
    check_eq("rstbusy_valid", {30'b0, mem_valid[0], if_valid[0]}, 32'd0);
    check_eq("rstbusy_state", {30'b0, dbg_state[0]}, 32'd0);
    if_req[0] = 1'b0; mem_req[0] = 1'b0;
    reset = 1'b0;
    last_mem[0] = 32'h0; last_mem[1] = 32'h0;
    repeat (3) @(negedge clk);
    check_eq("rstbusy_mem_rdata", mem_rdata[0], 32'd0);

    // Starvation limit 2 with both requests held: M, M, I, M, M, I
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_addr[0] = 32'h80; mem_ctrl[0] = 3'b010;
    order = ""; n = 0;
    for (int k = 0; k < 200 && n < 6; k++) begin
      #1;
      if (if_gnt[0])  begin order = {order, "I"}; n++; sb_push(0, 1'b1, ram_fn(32'h40)); end
      if (mem_gnt[0]) begin order = {order, "M"}; n++; sb_push(0, 1'b0, ram_fn(32'h80)); end
      if (n < 6) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    if_req[0] = 1'b0; mem_req[0] = 1'b0;
    n_checks++;
    if (order != "MMIMMI") begin
      n_errors++;
      $display("FAIL grant_order: got %s expected MMIMMI", order);
    end
    @(negedge clk);

    // Strict MEM priority, two wait states: IF never granted until MEM drops
    if_req[1] = 1'b1; if_addr[1] = 32'h300;
    mem_req[1] = 1'b1; mem_we[1] = 1'b0; mem_addr[1] = 32'h400; mem_ctrl[1] = 3'b010;
    mem_n = 0; ifg = 0;
    for (int k = 0; k < 400 && mem_n < 10; k++) begin
      #1;
      if (if_gnt[1]) ifg++;
      if (mem_gnt[1]) begin mem_n++; sb_push(1, 1'b0, ram_fn(32'h400)); end
      if (mem_n < 10) @(negedge clk);
    end
    check_eq("strict_mem_grants", mem_n, 32'd10);
    check_eq("strict_if_never", ifg, 32'd0);
    repeat (4) @(negedge clk);
    mem_req[1] = 1'b0;
    @(negedge clk);
    #1;
    check_eq("strict_if_next_idle", {31'b0, if_gnt[1]}, 32'd1);
    if (if_gnt[1]) sb_push(1, 1'b1, ram_fn(32'h300));
    repeat (4) @(negedge clk);
    if_req[1] = 1'b0;

    repeat (4) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
